// File: rtl/instr_encoder.sv
// RV32I program loader: packs instruction fields into a 32-bit word and writes it
// to instruction memory at an auto-incrementing address, rejecting unencodable fields.
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    R_TYPE = 3'd0, I_TYPE = 3'd1, S_TYPE = 3'd2,
    B_TYPE = 3'd3, U_TYPE = 3'd4, J_TYPE = 3'd5
  } instruction_t;

  localparam logic [6:0] OP_IMM = 7'h13;

  typedef struct packed {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;
endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_type,
  input  logic [6:0]    in_op,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7_5,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          full,
  output logic          err,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, FULL} state_t;

  state_t        r_state, w_nxt;
  fields_t       r_f;
  logic [31:0]   r_addr, r_word, w_word;
  logic [CW-1:0] r_cnt;
  logic          r_full, r_err, w_bad, w_last, w_shift;
  logic [6:0]    w_f7;

  // True when v is representable as an n-bit two's complement value.
  function automatic logic sfit(input logic [31:0] v, input int n);
    logic [31:0] s;
    s = $signed(v) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction

  assign w_f7    = {1'b0, r_f.f7_5, 5'b0};
  assign w_shift = (r_f.op == OP_IMM) && (r_f.f3[1:0] == 2'b01);
  assign w_last  = (r_cnt == CW'(DEPTH - 1));

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (r_f.typ)
      R_TYPE: w_word = {w_f7, r_f.rs2, r_f.rs1, r_f.f3, r_f.rd, r_f.op};
      I_TYPE: begin
        if (w_shift) begin
          w_word = {w_f7, r_f.imm[4:0], r_f.rs1, r_f.f3, r_f.rd, r_f.op};
          w_bad  = |r_f.imm[31:5];
        end else begin
          w_word = {r_f.imm[11:0], r_f.rs1, r_f.f3, r_f.rd, r_f.op};
          w_bad  = !sfit(r_f.imm, 12);
        end
      end
      S_TYPE: begin
        w_word = {r_f.imm[11:5], r_f.rs2, r_f.rs1, r_f.f3, r_f.imm[4:0], r_f.op};
        w_bad  = !sfit(r_f.imm, 12);
      end
      B_TYPE: begin
        w_word = {r_f.imm[12], r_f.imm[10:5], r_f.rs2, r_f.rs1, r_f.f3,
                  r_f.imm[4:1], r_f.imm[11], r_f.op};
        w_bad  = !sfit(r_f.imm, 13) || r_f.imm[0];
      end
      U_TYPE: w_word = {r_f.imm[31:12], r_f.rd, r_f.op};
      J_TYPE: begin
        w_word = {r_f.imm[20], r_f.imm[10:1], r_f.imm[11], r_f.imm[19:12], r_f.rd, r_f.op};
        w_bad  = !sfit(r_f.imm, 21) || r_f.imm[0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    if (prog_start) w_nxt = IDLE;
    else begin
      case (r_state)
        IDLE:    if (in_valid) w_nxt = ENCODE;
        ENCODE:  w_nxt = w_bad ? IDLE : WRITE;
        WRITE:   w_nxt = w_last ? FULL : IDLE;
        default: w_nxt = FULL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_f    <= '0;
      r_addr <= BASE_ADDR;
      r_word <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else if (prog_start) begin
      // Restart wins over everything, including an accept in the same cycle.
      r_addr <= BASE_ADDR;
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid)
          r_f <= '{typ: in_type, op: in_op, f3: in_funct3, f7_5: in_funct7_5,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
        ENCODE: begin
          if (w_bad) r_err  <= 1'b1;
          else       r_word <= w_word;
        end
        WRITE: begin
          r_addr <= r_addr + 32'd4;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign mem_we    = (r_state == WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_word;
  assign full      = r_full;
  assign err       = r_err;
  assign count     = r_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized checks of instr_encoder against an arithmetic encoding model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 0, rst_n = 0, prog_start = 0, in_valid = 0;
  logic          in_ready, mem_we, full, err, in_funct7_5 = 0;
  logic [2:0]    in_type = 0, in_funct3 = 0;
  logic [6:0]    in_op = 0;
  logic [4:0]    in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0]   in_imm = 0, mem_addr, mem_wdata;
  logic [CW-1:0] count;

  int n_pass = 0, n_total = 0, we_cnt = 0;
  int m_addr = 0, m_cnt = 0, m_wr = 0;
  bit m_full = 0, m_err = 0;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_type(in_type), .in_op(in_op), .in_funct3(in_funct3),
    .in_funct7_5(in_funct7_5), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .full(full), .err(err), .count(count));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference encoding built from field positions with shifts and masks.
  function automatic void model(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                                input logic f75, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output logic [31:0] w, output bit bad);
    int s = $signed(imm);
    logic [31:0] base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    logic [31:0] f7 = f75 ? 32'h4000_0000 : 32'h0;
    logic [31:0] rdf = 32'(rd) << 7;
    w = 0; bad = 0;
    case (t)
      3'd0: w = base | rdf | (32'(rs2) << 20) | f7;
      3'd1: if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
              bad = imm > 32'd31; w = base | rdf | ((imm & 31) << 20) | f7;
            end else begin
              bad = s < -2048 || s > 2047; w = base | rdf | ((imm & 32'hFFF) << 20);
            end
      3'd2: begin
              bad = s < -2048 || s > 2047;
              w = base | (32'(rs2) << 20) | (((imm >> 5) & 127) << 25) | ((imm & 31) << 7);
            end
      3'd3: begin
              bad = s < -4096 || s > 4095 || (s % 2 != 0);
              w = base | (32'(rs2) << 20) | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
                | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
            end
      3'd4: w = 32'(op) | rdf | (imm & 32'hFFFF_F000);
      3'd5: begin
              bad = s < -1048576 || s > 1048575 || (s % 2 != 0);
              w = 32'(op) | rdf | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12);
            end
      default: bad = 1;
    endcase
  endfunction

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w; bit bad;
    model(t, op, f3, f75, rd, rs1, rs2, imm, w, bad);
    @(negedge clk);
    in_type = t; in_op = op; in_funct3 = f3; in_funct7_5 = f75;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_imm = $urandom; in_rd = 5'($urandom); in_op = 7'($urandom);
    chk("enc_rdy", in_ready, 0);
    chk("enc_we", mem_we, 0);
    @(posedge clk); #1;
    if (bad) begin
      m_err = 1;
      chk("rej_we", mem_we, 0);
      chk("rej_err", err, 1);
      chk("rej_rdy", in_ready, 1);
      chk("rej_addr", mem_addr, m_addr);
      chk("rej_cnt", count, m_cnt);
    end else begin
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, m_addr);
      chk("wr_data", mem_wdata, w);
      @(posedge clk); #1;
      m_addr += 4; m_cnt++; m_wr++;
      if (m_cnt == DEPTH) m_full = 1;
      chk("post_we", mem_we, 0);
      chk("post_cnt", count, m_cnt);
      chk("post_full", full, m_full);
      chk("post_rdy", in_ready, !m_full);
      chk("post_err", err, m_err);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    prog_start = 1; in_valid = 1;
    @(posedge clk); #1;
    prog_start = 0; in_valid = 0;
    m_addr = 0; m_cnt = 0; m_full = 0; m_err = 0;
    chk("ps_rdy", in_ready, 1);
    chk("ps_addr", mem_addr, 0);
    chk("ps_full", full, 0);
    chk("ps_err", err, 0);
    chk("ps_cnt", count, 0);
    @(posedge clk); #1;
    chk("ps_noacc", in_ready, 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rdy", in_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", count, 0);
  endtask

  initial begin
    logic [31:0] imm_tbl [10] = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4095,
                                  -32'sd4096, 32'd31, 32'd32, 32'd1048575, -32'sd1048576};
    logic [6:0] op; logic [2:0] t, f3; logic [31:0] imm;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs();
    rst_n = 1;

    send(I_TYPE, 7'h13, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_word", mem_wdata, 32'h0050_0093);
    restart();
    send(R_TYPE, 7'h33, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0);
    send(U_TYPE, 7'h37, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    chk("lui_word", mem_wdata, 32'h1234_52B7);
    restart();
    send(B_TYPE, 7'h63, 3'd0, 0, 5'd0, 5'd0, 5'd0, -32'sd4);
    chk("beq_word", mem_wdata, 32'hFE00_0EE3);
    send(J_TYPE, 7'h6F, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd8);
    chk("jal_word", mem_wdata, 32'h0080_00EF);
    chk("jal_cnt", count, 2);
    send(B_TYPE, 7'h63, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd3);
    send(I_TYPE, 7'h13, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(I_TYPE, 7'h13, 3'd5, 1, 5'd4, 5'd4, 5'd0, 32'd7);
    send(S_TYPE, 7'h23, 3'd2, 0, 5'd0, 5'd2, 5'd9, -32'sd100);
    chk("full_flag", full, 1);
    @(negedge clk); in_valid = 1;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    chk("full_rdy", in_ready, 0);
    chk("full_nowr", we_cnt, m_wr);
    restart();

    // Reset while the bundle sits in ENCODE must never produce a write.
    @(negedge clk);
    in_type = I_TYPE; in_op = 7'h13; in_funct3 = 0; in_imm = 1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk_reset_outs();
    m_addr = 0; m_cnt = 0; m_full = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #1 chk("rst_nowr", we_cnt, m_wr);

    for (int i = 0; i < 60; i++) begin
      if (m_full) restart();
      t = 3'($urandom_range(0, 6));
      f3 = 3'($urandom);
      case (t)
        3'd0: op = 7'h33;
        3'd1: op = ($urandom_range(0, 2) == 0) ? 7'h03 : 7'h13;
        3'd2: op = 7'h23;
        3'd3: op = 7'h63;
        3'd4: op = $urandom_range(0, 1) ? 7'h37 : 7'h17;
        default: op = 7'h6F;
      endcase
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 63)) - 32'd32;
        1: imm = imm_tbl[$urandom_range(0, 9)];
        2: imm = $urandom;
        default: imm = 32'($urandom_range(0, 40)) & ~32'd1;
      endcase
      send(t, op, f3, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
    chk("final_wr", we_cnt, m_wr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
